// File: rtl/bam_pkg.sv
// ---------------------------------------------------------------------------
// bam_pkg
//
// Shared definitions for the Binary Angle Modulation (BAM) generator:
//   - default duty word width (number of BAM bit slots)
//   - default prescaler register width
//   - IDLE/RUN state encoding used by the controller and its status word
// ---------------------------------------------------------------------------
package bam_pkg;

    // Default duty word width; one bit slot per duty bit.
    localparam int BAM_WIDTH_DEF   = 8;

    // Default prescaler register width.
    localparam int PRESC_WIDTH_DEF = 16;

    // The encoding is visible to software: bit 0 of the status word is the
    // state, so RUN must stay 1'b1.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } bam_state_e;

endpackage : bam_pkg

// File: rtl/bam_prescaler.sv
// ---------------------------------------------------------------------------
// bam_prescaler
//
// Divides the system clock down to the BAM time base. The counter runs
// 0..limit and wraps, so one tick is produced every (limit + 1) clocks; a
// limit of 0 gives a tick on every clock.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_arst_n  asynchronous active-low reset
//   clear     synchronous clear; holds the counter at 0 and masks the tick
//   limit     terminal count (tick when the counter equals it)
//   tick      combinational tick, high for one clock per prescaler period
// ---------------------------------------------------------------------------
module bam_prescaler
    import bam_pkg::*;
#(
    parameter int PRESC_WIDTH = PRESC_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_arst_n,
    input  logic                   clear,
    input  logic [PRESC_WIDTH-1:0] limit,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] cnt;
    logic                   at_limit;

    // The limit only changes when the counter wraps, so the counter never
    // passes it; >= still lets a corrupted count recover in one clock.
    assign at_limit = (cnt >= limit);
    assign tick     = !clear && at_limit;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt <= '0;
        end else if (clear || at_limit) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_WIDTH'(1);
        end
    end

endmodule : bam_prescaler

// File: rtl/bam_gen.sv
// ---------------------------------------------------------------------------
// bam_gen
//
// Binary Angle Modulation generator. A period consists of BAM_WIDTH bit
// slots, LSB first; slot k lasts 2^k prescaler ticks and drives the output
// with duty bit k, so a period is 2^BAM_WIDTH - 1 ticks long.
//
// Software writes go to pending duty/prescaler registers. The active copies
// that shape the waveform are loaded from them only when the generator is
// enabled or at a period end, so a write never disturbs a period that is
// already under way.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_arst_n       asynchronous active-low reset
//   i_DATA         write data bus
//   i_DUTY_WE      pending duty      <= i_DATA[BAM_WIDTH-1:0]
//   i_PRESC_WE     pending prescaler <= i_DATA[PRESC_WIDTH-1:0]
//   i_CTRL_WE      enable            <= i_DATA[0]
//   o_BAM          registered BAM waveform
//   o_ALT_EN       high while running (GPIO alternate-function select)
//   o_PERIOD_DONE  one-clock pulse after each completed period
//   o_STATUS       {pending duty, active duty, state}, zero-extended
//
// Parameter limits: 2 <= BAM_WIDTH, 2*BAM_WIDTH + 1 <= 32, PRESC_WIDTH <= 32.
// ---------------------------------------------------------------------------
module bam_gen
    import bam_pkg::*;
#(
    parameter int BAM_WIDTH   = BAM_WIDTH_DEF,
    parameter int PRESC_WIDTH = PRESC_WIDTH_DEF
) (
    input  logic        i_clk,
    input  logic        i_arst_n,
    input  logic [31:0] i_DATA,
    input  logic        i_DUTY_WE,
    input  logic        i_PRESC_WE,
    input  logic        i_CTRL_WE,
    output logic        o_BAM,
    output logic        o_ALT_EN,
    output logic        o_PERIOD_DONE,
    output logic [31:0] o_STATUS
);

    localparam int IDX_W = $clog2(BAM_WIDTH);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    bam_state_e             state;
    logic [BAM_WIDTH-1:0]   pend_duty;
    logic [BAM_WIDTH-1:0]   act_duty;
    logic [PRESC_WIDTH-1:0] pend_presc;
    logic [PRESC_WIDTH-1:0] act_presc;
    logic [IDX_W-1:0]       bit_idx;
    logic [BAM_WIDTH-1:0]   weight_cnt;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic                   running;
    logic                   start;
    logic                   stop;
    logic                   tick;
    logic [BAM_WIDTH-1:0]   weight_max;
    logic                   slot_end;
    logic                   last_slot;
    logic [BAM_WIDTH-1:0]   pend_duty_nxt;
    logic [PRESC_WIDTH-1:0] pend_presc_nxt;
    logic                   unused_data;

    assign running = (state == ST_RUN);

    // An enable while already running is not a restart, and a disable while
    // idle has nothing to stop.
    assign start = i_CTRL_WE &&  i_DATA[0] && !running;
    assign stop  = i_CTRL_WE && !i_DATA[0] &&  running;

    // Value the pending registers hold after this edge. Loading the active
    // registers from these on an enable makes a duty/prescaler write that
    // shares the enable cycle take effect immediately.
    assign pend_duty_nxt  = i_DUTY_WE  ? i_DATA[BAM_WIDTH-1:0]   : pend_duty;
    assign pend_presc_nxt = i_PRESC_WE ? i_DATA[PRESC_WIDTH-1:0] : pend_presc;

    // Slot k lasts 2^k ticks: the weight counter runs 0..2^k-1.
    assign weight_max = (BAM_WIDTH'(1) << bit_idx) - BAM_WIDTH'(1);
    assign slot_end   = tick && (weight_cnt == weight_max);
    assign last_slot  = (bit_idx == IDX_W'(BAM_WIDTH - 1));

    // Only the low bits of the bus are used by any register.
    assign unused_data = ^i_DATA;

    // -----------------------------------------------------------------------
    // Time base: held cleared while idle, so the first RUN cycle starts at 0.
    // -----------------------------------------------------------------------
    bam_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .clear    (!running),
        .limit    (act_presc),
        .tick     (tick)
    );

    // -----------------------------------------------------------------------
    // Pending registers: written by software in any state.
    // -----------------------------------------------------------------------
    // NOTE: non-blocking assignments mean the period-end reload below reads
    // the pending value from before this edge, so a write that lands on the
    // reload edge is kept in pending and used at the next period end.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pend_duty  <= '0;
            pend_presc <= '0;
        end else begin
            pend_duty  <= pend_duty_nxt;
            pend_presc <= pend_presc_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Controller: state, active registers, slot counters, registered outputs
    // -----------------------------------------------------------------------
    // NOTE: every register here, outputs included, has a reset value so that
    // o_BAM and o_PERIOD_DONE are 0 from the moment reset asserts and an
    // interrupted period can never complete.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state         <= ST_IDLE;
            act_duty      <= '0;
            act_presc     <= '0;
            bit_idx       <= '0;
            weight_cnt    <= '0;
            o_BAM         <= 1'b0;
            o_PERIOD_DONE <= 1'b0;
        end else begin
            o_PERIOD_DONE <= 1'b0;

            case (state)
                ST_IDLE: begin
                    o_BAM <= 1'b0;
                    if (start) begin
                        state      <= ST_RUN;
                        act_duty   <= pend_duty_nxt;
                        act_presc  <= pend_presc_nxt;
                        bit_idx    <= '0;
                        weight_cnt <= '0;
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        // Abort at once; the output must already be low in
                        // the first idle cycle, so it is not left to lag.
                        state      <= ST_IDLE;
                        o_BAM      <= 1'b0;
                        bit_idx    <= '0;
                        weight_cnt <= '0;
                    end else begin
                        // One clock behind the slot registers.
                        o_BAM <= act_duty[bit_idx];

                        if (slot_end) begin
                            weight_cnt <= '0;
                            if (last_slot) begin
                                bit_idx       <= '0;
                                o_PERIOD_DONE <= 1'b1;
                                act_duty      <= pend_duty;
                                act_presc     <= pend_presc;
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end else if (tick) begin
                            weight_cnt <= weight_cnt + BAM_WIDTH'(1);
                        end
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs derived directly from registers
    // -----------------------------------------------------------------------
    assign o_ALT_EN = running;
    assign o_STATUS = 32'({pend_duty, act_duty, running});

endmodule : bam_gen
